dq4_write_ctrl: RTL and testbench

Clocked write controller sitting directly upstream of the 4-bit gated DQ latch array. It accepts a data word over a valid/ready handshake and drives the latch bank's D bus and en strobe with programmable setup, pulse and hold windows. It then reads the latch outputs back and flags any mismatch. It turns the level-sensitive latch bank into a safe, synchronous write target for the clocked logic around it.

---
 rtl/dq4_write_ctrl_pkg.sv | 24 ++
 rtl/dq4_write_ctrl_phase_cnt.sv | 33 +++
 rtl/dq4_write_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dq4_write_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dq4_write_ctrl_pkg.sv
// Shared constants for the DQ4 write controller.
//   - FSM state encoding (3-bit legacy-compatible constants)
//   - phase counter width
//   - mismatch counter width, saturation value and saturating increment helper
package dq4_write_ctrl_pkg;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StIdle  = 3'd0;
    localparam logic [StateW-1:0] StSetup = 3'd1;
    localparam logic [StateW-1:0] StPulse = 3'd2;
    localparam logic [StateW-1:0] StHold  = 3'd3;
    localparam logic [StateW-1:0] StCheck = 3'd4;

    localparam int unsigned CntW = 4;

    localparam int unsigned        ErrCntW   = 8;
    localparam logic [ErrCntW-1:0] ErrCntMax = 8'd255;

    function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
        return (v == ErrCntMax) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dq4_write_ctrl_phase_cnt.sv
// Loadable down-counter shared by the setup, pulse and hold phases.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - load load_val (takes priority over dec)
//   load_val    - value to load
//   dec         - decrement; holds at zero
//   zero        - counter currently equals zero
module dq4_write_ctrl_phase_cnt
    import dq4_write_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dq4_write_ctrl.sv
// Synchronous write controller for a level-sensitive gated DQ latch bank.
// Accepts a word over valid/ready, drives D with programmable setup, en pulse and
// hold windows, then compares the latch readback and records mismatches.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   wr_data, wr_valid  - write request; wr_ready high while idle
//   D, en              - registered data bus and enable strobe to the latch bank
//   Q                  - latch bank readback
//   err_clr            - clears err and err_cnt
//   done               - one-cycle pulse at the end of each write
//   err, err_cnt       - sticky mismatch flag and saturating mismatch count
module dq4_write_ctrl
    import dq4_write_ctrl_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [W-1:0]       D,
    output logic               en,
    input  logic [W-1:0]       Q,
    input  logic               err_clr,
    output logic               done,
    output logic               err,
    output logic [ErrCntW-1:0] err_cnt
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $fatal(1, "dq4_write_ctrl: SETUP_CYC must be in 1..15");
    end
    if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
        $fatal(1, "dq4_write_ctrl: PULSE_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $fatal(1, "dq4_write_ctrl: HOLD_CYC must be in 1..15");
    end

    // Counter loads N-1 so each phase lasts exactly N cycles.
    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

    logic [StateW-1:0]  state_q, state_d;
    logic [W-1:0]       d_q, d_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

    logic            cnt_load;
    logic [CntW-1:0] cnt_ld_val;
    logic            cnt_dec;
    logic            cnt_zero;

    dq4_write_ctrl_phase_cnt u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        en_d       = en_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        cnt_load   = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;

        // Clear first so a same-edge mismatch overrides it (count restarts at 1).
        if (err_clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (wr_valid) begin
                    d_d        = wr_data;
                    cnt_load   = 1'b1;
                    cnt_ld_val = SetupLd;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    en_d       = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_ld_val = PulseLd;
                    state_d    = StPulse;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StPulse: begin
                if (cnt_zero) begin
                    en_d       = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_ld_val = HoldLd;
                    state_d    = StHold;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StCheck;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StCheck: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (Q != d_q) begin
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_d);
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            d_q       <= '0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            en_q      <= en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wr_ready = (state_q == StIdle);
    assign D        = d_q;
    assign en       = en_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dq4_write_ctrl.sv
// Directed bench for dq4_write_ctrl: a default-timing instance (a) and a
// SETUP=2/PULSE=3/HOLD=2 instance (b), each feeding a behavioural DQ4 latch.
module tb_dq4_write_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: default timing
    logic [3:0] wr_data_a;
    logic       wr_valid_a;
    logic       wr_ready_a;
    logic [3:0] d_a;
    logic       en_a;
    logic [3:0] q_a;
    logic       err_clr_a;
    logic       done_a;
    logic       err_a;
    logic [7:0] err_cnt_a;
    logic [3:0] lat_a = 4'h0;
    logic       force_q;
    logic [3:0] force_val;

    always @(en_a or d_a) if (en_a) lat_a = d_a;
    assign q_a = force_q ? force_val : lat_a;

    dq4_write_ctrl u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data_a),
        .wr_valid (wr_valid_a),
        .wr_ready (wr_ready_a),
        .D        (d_a),
        .en       (en_a),
        .Q        (q_a),
        .err_clr  (err_clr_a),
        .done     (done_a),
        .err      (err_a),
        .err_cnt  (err_cnt_a)
    );

    // Instance b: stretched timing
    logic [3:0] wr_data_b;
    logic       wr_valid_b;
    logic       wr_ready_b;
    logic [3:0] d_b;
    logic       en_b;
    logic [3:0] lat_b = 4'h0;
    logic       err_clr_b;
    logic       done_b;
    logic       err_b;
    logic [7:0] err_cnt_b;

    always @(en_b or d_b) if (en_b) lat_b = d_b;

    dq4_write_ctrl #(
        .W         (4),
        .SETUP_CYC (2),
        .PULSE_CYC (3),
        .HOLD_CYC  (2)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data_b),
        .wr_valid (wr_valid_b),
        .wr_ready (wr_ready_b),
        .D        (d_b),
        .en       (en_b),
        .Q        (lat_b),
        .err_clr  (err_clr_b),
        .done     (done_b),
        .err      (err_b),
        .err_cnt  (err_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one word on instance a and wait until its done pulse is visible.
    task automatic write_a(input logic [3:0] data, output bit timed_out);
        wr_data_a  = data;
        wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        timed_out  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done_a) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (wr_ready_a !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready got %0b exp 1", wr_ready_a);
        end
        checks++;
        if (d_a !== 4'h0 || en_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got D=%0h en=%0b done=%0b exp 0/0/0",
                               d_a, en_a, done_a);
        end
        checks++;
        if (err_a !== 1'b0 || err_cnt_a !== 8'd0) begin
            errors++; $display("FAIL reset_err got err=%0b cnt=%0d exp 0/0", err_a, err_cnt_a);
        end
    endtask

    task automatic test_basic_write();
        wr_data_a  = 4'b1010;
        wr_valid_a = 1'b1;
        tick();                             // handshake edge
        wr_valid_a = 1'b0;
        checks++;
        if (wr_ready_a !== 1'b0 || d_a !== 4'b1010 || en_a !== 1'b0) begin
            errors++; $display("FAIL basic_setup got rdy=%0b D=%0h en=%0b exp 0/a/0",
                               wr_ready_a, d_a, en_a);
        end
        tick();
        checks++;
        if (en_a !== 1'b1 || d_a !== 4'b1010) begin
            errors++; $display("FAIL basic_pulse got en=%0b D=%0h exp 1/a", en_a, d_a);
        end
        tick();
        checks++;
        if (en_a !== 1'b0 || q_a !== 4'b1010 || d_a !== 4'b1010) begin
            errors++; $display("FAIL basic_hold got en=%0b Q=%0h D=%0h exp 0/a/a", en_a, q_a, d_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b0 || en_a !== 1'b0 || wr_ready_a !== 1'b0) begin
            errors++; $display("FAIL basic_check got done=%0b en=%0b rdy=%0b exp 0/0/0",
                               done_a, en_a, wr_ready_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b1 || wr_ready_a !== 1'b1 || err_a !== 1'b0 || d_a !== 4'b1010) begin
            errors++; $display("FAIL basic_done got done=%0b rdy=%0b err=%0b D=%0h exp 1/1/0/a",
                               done_a, wr_ready_a, err_a, d_a);
        end
        // Next handshake lands 5 edges after the first one.
        wr_data_a  = 4'b0101;
        wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        checks++;
        if (done_a !== 1'b0 || wr_ready_a !== 1'b0 || d_a !== 4'b0101) begin
            errors++; $display("FAIL basic_second_hs got done=%0b rdy=%0b D=%0h exp 0/0/5",
                               done_a, wr_ready_a, d_a);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done_a !== 1'b1 || q_a !== 4'b0101 || err_a !== 1'b0) begin
            errors++; $display("FAIL basic_second_done got done=%0b Q=%0h err=%0b exp 1/5/0",
                               done_a, q_a, err_a);
        end
    endtask

    task automatic test_mismatch();
        bit to;
        force_q   = 1'b1;
        force_val = 4'b0000;
        write_a(4'b0110, to);
        checks++;
        if (to || err_a !== 1'b1 || err_cnt_a !== 8'd1) begin
            errors++; $display("FAIL mismatch_flag got to=%0b err=%0b cnt=%0d exp 0/1/1",
                               to, err_a, err_cnt_a);
        end
        force_q = 1'b0;
        tick();
        checks++;
        if (err_a !== 1'b1 || err_cnt_a !== 8'd1) begin
            errors++; $display("FAIL mismatch_sticky got err=%0b cnt=%0d exp 1/1", err_a, err_cnt_a);
        end
        err_clr_a = 1'b1;
        tick();
        err_clr_a = 1'b0;
        checks++;
        if (err_a !== 1'b0 || err_cnt_a !== 8'd0) begin
            errors++; $display("FAIL mismatch_clear got err=%0b cnt=%0d exp 0/0", err_a, err_cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        int hs_cyc;
        int prev_hs;
        int en_cnt;
        bit d_bad;
        bit seen;
        wr_valid_b = 1'b1;
        prev_hs    = 0;
        for (int k = 1; k <= 4; k++) begin
            wr_data_b = 4'(k);
            checks++;
            if (wr_ready_b !== 1'b1) begin
                errors++; $display("FAIL b2b_ready word %0d got %0b exp 1", k, wr_ready_b);
            end
            hs_cyc = cyc;
            tick();
            en_cnt = 0;
            d_bad  = 1'b0;
            seen   = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (done_b) begin
                    seen = 1'b1;
                    break;
                end
                if (en_b) en_cnt++;
                if (d_b !== 4'(k)) d_bad = 1'b1;
                tick();
            end
            checks++;
            if (!seen || en_cnt != 3 || d_bad) begin
                errors++; $display("FAIL b2b_word%0d got done=%0b en_cycles=%0d d_bad=%0b exp 1/3/0",
                                   k, seen, en_cnt, d_bad);
            end
            checks++;
            if (lat_b !== 4'(k)) begin
                errors++; $display("FAIL b2b_latched%0d got %0h exp %0h", k, lat_b, k);
            end
            if (k > 1) begin
                checks++;
                if (hs_cyc - prev_hs != 9) begin
                    errors++; $display("FAIL b2b_period%0d got %0d exp 9", k, hs_cyc - prev_hs);
                end
            end
            prev_hs = hs_cyc;
        end
        wr_valid_b = 1'b0;
        tick();
        checks++;
        if (err_b !== 1'b0 || err_cnt_b !== 8'd0) begin
            errors++; $display("FAIL b2b_err got err=%0b cnt=%0d exp 0/0", err_b, err_cnt_b);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int done_seen;
        wr_data_a  = 4'b1111;
        wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        tick();
        checks++;
        if (en_a !== 1'b1) begin
            errors++; $display("FAIL rstpulse_en_before got %0b exp 1", en_a);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (en_a !== 1'b0 || d_a !== 4'h0 || wr_ready_a !== 1'b1 || err_a !== 1'b0) begin
            errors++; $display("FAIL rstpulse_after got en=%0b D=%0h rdy=%0b err=%0b exp 0/0/1/0",
                               en_a, d_a, wr_ready_a, err_a);
        end
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_a) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0 || err_a !== 1'b0) begin
            errors++; $display("FAIL rstpulse_no_done got done_cycles=%0d err=%0b exp 0/0",
                               done_seen, err_a);
        end
    endtask

    task automatic test_saturation();
        bit to;
        bit any_to;
        logic [7:0] cnt_at_255;
        force_q    = 1'b1;
        force_val  = 4'b0000;
        any_to     = 1'b0;
        cnt_at_255 = 8'd0;
        for (int i = 0; i < 256; i++) begin
            write_a(4'b1001, to);
            if (to) any_to = 1'b1;
            if (i == 254) cnt_at_255 = err_cnt_a;
            tick();
        end
        checks++;
        if (any_to) begin
            errors++; $display("FAIL sat_timeout got timeout=1 exp 0");
        end
        checks++;
        if (cnt_at_255 !== 8'd255) begin
            errors++; $display("FAIL sat_reach got %0d exp 255", cnt_at_255);
        end
        checks++;
        if (err_cnt_a !== 8'd255 || err_a !== 1'b1) begin
            errors++; $display("FAIL sat_hold got cnt=%0d err=%0b exp 255/1", err_cnt_a, err_a);
        end
    endtask

    // Counter is at 255 on entry, so a clear+mismatch must restart it at exactly 1.
    task automatic test_clr_collision();
        force_q    = 1'b1;
        force_val  = 4'b0000;
        wr_data_a  = 4'b0011;
        wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        tick();
        tick();
        tick();                             // now in CHECK
        err_clr_a = 1'b1;
        tick();                             // CHECK-exit edge
        err_clr_a = 1'b0;
        checks++;
        if (done_a !== 1'b1 || err_a !== 1'b1 || err_cnt_a !== 8'd1) begin
            errors++; $display("FAIL clr_collision got done=%0b err=%0b cnt=%0d exp 1/1/1",
                               done_a, err_a, err_cnt_a);
        end
        force_q = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_data_a  = 4'h0;
        wr_valid_a = 1'b0;
        err_clr_a  = 1'b0;
        force_q    = 1'b0;
        force_val  = 4'h0;
        wr_data_b  = 4'h0;
        wr_valid_b = 1'b0;
        err_clr_b  = 1'b0;
        #1;
        test_reset();
        test_basic_write();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_pulse();
        test_saturation();
        test_clr_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
